// File: rtl/ifq_pkg.sv
// Purpose : shared types and constants for the instruction-fetch queue.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: default XLEN, instruction size in bytes, the NOP encoding and
//           the {pc, insn} fetch entry layout at the default width.
package ifq_pkg;

   localparam int          XLEN       = 32;
   localparam int          INSN_BYTES = 4;
   localparam logic [31:0] NOP_INSN   = 32'h0000_0013;  // addi x0, x0, 0

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Purpose : DEPTH-entry circular buffer of fetch entries with flush.
// Latency : a push at edge N is visible on o_rdata from cycle N+1.
// Backpr. : caller must not push when o_full or pop when o_empty.
// Ports   : i_clk/i_rst (sync, active-high), i_flush clears pointers and
//           count, i_push/i_wdata write at the tail, i_pop advances the
//           head, o_rdata is the head entry, o_count/o_full/o_empty status.
module ifq_fifo #(
   parameter  int W     = 64,
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   output logic [W-1:0]  o_rdata,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q;

   // Storage needs no reset: only entries below the count are ever read.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush && !i_rst) begin
         mem_q[wptr_q] <= i_wdata;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (i_push) wptr_q <= wptr_q + PW'(1);
         if (i_pop)  rptr_q <= rptr_q + PW'(1);
         unique case ({i_push, i_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign o_rdata = mem_q[rptr_q];
   assign o_count = cnt_q;
   assign o_full  = (cnt_q == CW'(DEPTH));
   assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Purpose : fetch front end; owns the fetch PC, issues word reads and
//           queues {pc, insn} pairs for decode. Optional macro
//           IFQ_BYPASS_EN forwards a memory return straight to decode when
//           the queue is empty.
// Latency : 1 cycle memory-to-decode (0 cycles with IFQ_BYPASS_EN, empty).
// Backpr. : o_imem_req drops while the queue is full; decode stalls via
//           i_insn_rdy, head outputs hold steady while stalled.
// Ports   : i_clk/i_rst sync active-high; o_imem_addr/o_imem_req and
//           i_imem_rdata/i_imem_vld to instruction memory; i_redirect and
//           i_redirect_pc flush and restart fetch; o_insn/o_insn_pc/
//           o_insn_vld/i_insn_rdy to decode; o_count is queue occupancy.
module ifetch_queue
   import ifq_pkg::*;
#(
   parameter  int              XLEN         = ifq_pkg::XLEN,
   parameter  int              DEPTH        = 4,
   parameter  logic [XLEN-1:0] RESET_VECTOR = '0,
   localparam int              CW           = $clog2(DEPTH) + 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic [XLEN-1:0] o_imem_addr,
   output logic            o_imem_req,
   input  logic [XLEN-1:0] i_imem_rdata,
   input  logic            i_imem_vld,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [XLEN-1:0] o_insn,
   output logic [XLEN-1:0] o_insn_pc,
   output logic            o_insn_vld,
   input  logic            i_insn_rdy,
   output logic [CW-1:0]   o_count
);

   // Same layout as ifq_pkg::fetch_entry_t, sized by this instance's XLEN.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } entry_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   entry_t          wr_entry, head_entry, out_entry;
   logic            fifo_empty, fifo_full;
   logic            fetch_fire, push, fifo_pop, vld_raw;

   assign o_imem_req  = ~fifo_full;
   assign o_imem_addr = fetch_pc_q;

   // A word is accepted from memory whenever it is offered, we asked for
   // it and no redirect is discarding the current fetch stream.
   assign fetch_fire = o_imem_req & i_imem_vld & ~i_redirect;

   assign wr_entry.pc   = fetch_pc_q;
   assign wr_entry.insn = i_imem_rdata;

`ifdef IFQ_BYPASS_EN
   logic byp;
   // Empty queue: the returning word is the head this very cycle. If
   // decode takes it now it never touches the storage.
   assign byp       = fifo_empty & fetch_fire;
   assign vld_raw   = ~fifo_empty | byp;
   assign out_entry = fifo_empty ? wr_entry : head_entry;
   assign push      = fetch_fire & ~(byp & i_insn_rdy);
`else
   assign vld_raw   = ~fifo_empty;
   assign out_entry = head_entry;
   assign push      = fetch_fire;
`endif

   // Gated by reset so decode sees nothing while reset is held.
   assign o_insn_vld = vld_raw & ~i_rst;
   assign o_insn     = o_insn_vld ? out_entry.insn : XLEN'(NOP_INSN);
   assign o_insn_pc  = o_insn_vld ? out_entry.pc   : '0;

   // Only queued entries are popped; a bypassed word leaves no entry.
   assign fifo_pop = ~fifo_empty & o_insn_vld & i_insn_rdy;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (i_redirect) begin
         fetch_pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
      end else if (fetch_fire) begin
         fetch_pc_d = fetch_pc_q + XLEN'(INSN_BYTES);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_pc_q <= RESET_VECTOR;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   ifq_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_redirect),
      .i_push  (push),
      .i_wdata (wr_entry),
      .i_pop   (fifo_pop),
      .o_rdata (head_entry),
      .o_count (o_count),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

endmodule
